// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: key codes, display codes,
// FSM states and the arithmetic operator encoding.
package calc_pkg;

  // Key codes (0-9 are decimal digits)
  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_DIV   = 4'd13;
  localparam logic [3:0] KEY_CLEAR = 4'd14;
  localparam logic [3:0] KEY_ENTER = 4'd15;

  // Display codes (0-9 are decimal digits)
  localparam logic [3:0] DISP_ADD   = 4'hA;
  localparam logic [3:0] DISP_SUB   = 4'hB;
  localparam logic [3:0] DISP_MUL   = 4'hC;
  localparam logic [3:0] DISP_DIV   = 4'hD;
  localparam logic [3:0] DISP_ERR   = 4'hE;
  localparam logic [3:0] DISP_BLANK = 4'hF;

  typedef enum logic [1:0] {
    A_ENT = 2'd0,
    B_ENT = 2'd1,
    CONV  = 2'd2,
    SHOW  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic [3:0] op_disp(input op_e op);
    case (op)
      OP_ADD:  return DISP_ADD;
      OP_SUB:  return DISP_SUB;
      OP_MUL:  return DISP_MUL;
      OP_DIV:  return DISP_DIV;
      default: return DISP_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one result bit per cycle, BIN_W
// cycles per conversion. abort drops an in-flight conversion silently.
module bin2bcd_seq #(
  parameter int BIN_W = 14,
  parameter int DIG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [4*DIG-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIG;

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // Add-3 correction of every BCD digit that is 5 or more before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state: load on start, shift one bit per cycle while running
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = CNT_W'(BIN_W);
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = BCD_W'({bcd_adj, bin_q[BIN_W-1]});
      bin_d = bin_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) run_d = 1'b0;
    end
  end

  // Converter state registers
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers are only assigned with <= so every flop samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: bcd_q is small datapath state, so it is reset too; the display never shows X after power-up.
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign busy = run_q;
  assign done = run_q && (cnt_q == CNT_W'(1)) && !abort;
  assign bcd  = bcd_q;

endmodule

// File: rtl/calc_fsm_param.sv
// Four-function keypad calculator with BCD display.
// Optional feature: define CALC_DIV_EN to enable the division key (13);
// without it key 13 is ignored and no divider is built.
module calc_fsm_param #(
  parameter int OP_DIG   = 2,
  parameter int DISP_DIG = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key,
  output logic [4*DISP_DIG-1:0] disp_bcd,
  output logic                  busy,
  output logic                  result_valid
);

  import calc_pkg::*;

  localparam int RES_DIG = 2 * OP_DIG;
  localparam int RES_W   = $clog2(10 ** RES_DIG);
  localparam int OPW4    = 4 * OP_DIG;

  if (OP_DIG < 1 || OP_DIG > 4) begin : g_bad_op_dig
    $error("calc_fsm_param: OP_DIG must be 1..4");
  end
  if (DISP_DIG < 2 * OP_DIG + 1) begin : g_bad_disp_dig
    $error("calc_fsm_param: DISP_DIG must be >= 2*OP_DIG+1");
  end

  state_e            state_q, state_d;
  logic [OPW4-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]        a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  op_e               op_q, op_d;
  logic              neg_q, neg_d, err_q, err_d;
  logic              res_valid_q, res_valid_d;

  logic              key_clear, key_op;
  op_e               key_op_code;
  logic [RES_W-1:0]  a_val, b_val, res;
  logic              res_neg, res_err;
  logic              conv_start, conv_done, conv_busy;
  logic [4*RES_DIG-1:0] conv_bcd;
  logic              lead_zero;

  // Operands are held as BCD digits; this folds them into a binary value
  function automatic logic [RES_W-1:0] digits_to_bin(input logic [OPW4-1:0] d);
    logic [RES_W-1:0] v;
    v = '0;
    for (int i = OP_DIG - 1; i >= 0; i--) v = v * RES_W'(10) + RES_W'(d[4*i +: 4]);
    return v;
  endfunction

  assign key_clear  = key_valid && (key == KEY_CLEAR);
  assign conv_start = (state_q == B_ENT) && key_valid && (key == KEY_ENTER);
  assign a_val      = digits_to_bin(a_q);
  assign b_val      = digits_to_bin(b_q);

  // Decode operator keys; key 13 only counts when division is built in
  always_comb begin
    key_op      = 1'b1;
    key_op_code = OP_ADD;
    case (key)
      KEY_ADD: key_op_code = OP_ADD;
      KEY_SUB: key_op_code = OP_SUB;
      KEY_MUL: key_op_code = OP_MUL;
`ifdef CALC_DIV_EN
      KEY_DIV: key_op_code = OP_DIV;
`endif
      default: key_op = 1'b0;
    endcase
  end

  // Result of the latched operation on the two entered operands
  always_comb begin
    res     = '0;
    res_neg = 1'b0;
    res_err = 1'b0;
    case (op_q)
      OP_ADD: res = a_val + b_val;
      OP_SUB: begin
        if (a_val < b_val) begin
          res     = b_val - a_val;
          res_neg = 1'b1;
        end else begin
          res = a_val - b_val;
        end
      end
      OP_MUL: res = a_val * b_val;
`ifdef CALC_DIV_EN
      OP_DIV: begin
        if (b_val == '0) res_err = 1'b1;
        else             res = a_val / b_val;
      end
`endif
      default: res = '0;
    endcase
  end

  // Key-driven state machine; clear wins over everything, including CONV
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    a_cnt_d     = a_cnt_q;
    b_d         = b_q;
    b_cnt_d     = b_cnt_q;
    op_d        = op_q;
    neg_d       = neg_q;
    err_d       = err_q;
    res_valid_d = 1'b0;
    if (key_clear) begin
      state_d = A_ENT;
      a_d     = '0;
      a_cnt_d = '0;
      b_d     = '0;
      b_cnt_d = '0;
      op_d    = OP_ADD;
      neg_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        A_ENT: begin
          if (key_valid && is_digit(key)) begin
            if (a_cnt_q < 3'(OP_DIG)) begin
              a_d     = OPW4'({a_q, key});
              a_cnt_d = a_cnt_q + 3'd1;
            end
          end else if (key_valid && key_op) begin
            op_d    = key_op_code;
            state_d = B_ENT;
          end
        end
        B_ENT: begin
          if (key_valid && is_digit(key)) begin
            if (b_cnt_q < 3'(OP_DIG)) begin
              b_d     = OPW4'({b_q, key});
              b_cnt_d = b_cnt_q + 3'd1;
            end
          end else if (key_valid && key_op) begin
            op_d = key_op_code;
          end else if (conv_start) begin
            neg_d   = res_neg;
            err_d   = res_err;
            state_d = CONV;
          end
        end
        CONV: begin
          if (conv_done) begin
            state_d     = SHOW;
            res_valid_d = 1'b1;
          end
        end
        SHOW: begin
          if (key_valid && is_digit(key)) begin
            a_d     = OPW4'(key);
            a_cnt_d = 3'd1;
            b_d     = '0;
            b_cnt_d = '0;
            state_d = A_ENT;
          end
        end
        default: state_d = A_ENT;
      endcase
    end
  end

  // Controller registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= A_ENT;
      a_q         <= '0;
      a_cnt_q     <= '0;
      b_q         <= '0;
      b_cnt_q     <= '0;
      op_q        <= OP_ADD;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      a_cnt_q     <= a_cnt_d;
      b_q         <= b_d;
      b_cnt_q     <= b_cnt_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
    end
  end

  bin2bcd_seq #(
    .BIN_W (RES_W),
    .DIG   (RES_DIG)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .abort (key_clear),
    .bin   (res),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Display mapping: right-aligned operand entry, or blanked result in SHOW
  always_comb begin
    disp_bcd  = {DISP_DIG{DISP_BLANK}};
    lead_zero = 1'b1;
    case (state_q)
      A_ENT: begin
        for (int i = 0; i < OP_DIG; i++) begin
          if (3'(i) < a_cnt_q) disp_bcd[4*i +: 4] = a_q[4*i +: 4];
        end
      end
      B_ENT, CONV: begin
        for (int i = 0; i < OP_DIG; i++) begin
          if (3'(i) < b_cnt_q) disp_bcd[4*i +: 4] = b_q[4*i +: 4];
        end
        disp_bcd[4*(DISP_DIG-1) +: 4] = op_disp(op_q);
      end
      SHOW: begin
        if (err_q) begin
          disp_bcd = {DISP_DIG{DISP_ERR}};
        end else begin
          for (int i = RES_DIG - 1; i >= 0; i--) begin
            if (!(lead_zero && (conv_bcd[4*i +: 4] == 4'd0) && (i != 0))) begin
              lead_zero          = 1'b0;
              disp_bcd[4*i +: 4] = conv_bcd[4*i +: 4];
            end
          end
          if (neg_q) disp_bcd[4*(DISP_DIG-1) +: 4] = DISP_SUB;
        end
      end
      default: disp_bcd = {DISP_DIG{DISP_BLANK}};
    endcase
  end

  assign busy         = conv_busy;
  assign result_valid = res_valid_q;

endmodule

// File: tb/tb_calc_fsm_param.sv
// Self-checking bench for calc_fsm_param (OP_DIG=2, DISP_DIG=5): directed
// key sequences followed by random key streams against a decimal model.
module tb_calc_fsm_param;

  localparam int OP_DIG   = 2;
  localparam int DISP_DIG = 5;
  localparam int DW       = 4 * DISP_DIG;
`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          key_valid;
  logic [3:0]    key;
  logic [DW-1:0] disp_bcd;
  logic          busy;
  logic          result_valid;

  calc_fsm_param #(
    .OP_DIG   (OP_DIG),
    .DISP_DIG (DISP_DIG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key          (key),
    .disp_bcd     (disp_bcd),
    .busy         (busy),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int res_w;
  bit rand_abort = 1'b0;

  // Behavioural calculator model: operands as integers plus digit counts
  typedef enum {MD_A, MD_B, MD_SHOW} mode_t;
  mode_t md;
  int    a_val, a_n, b_val, b_n, op_k;
  int    sh_val;
  bit    sh_neg, sh_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ceil(log2(10^(2*OP_DIG))) by counting powers of two
  function automatic int calc_res_w();
    longint lim = 1;
    int     w   = 0;
    for (int i = 0; i < 2 * OP_DIG; i++) lim = lim * 10;
    while ((longint'(1) << w) < lim) w++;
    return w;
  endfunction

  function automatic bit model_is_op(input int k);
    return (k >= 10 && k <= 12) || (k == 13 && DIV_EN);
  endfunction

  task automatic model_reset();
    md = MD_A; a_val = 0; a_n = 0; b_val = 0; b_n = 0; op_k = 10;
    sh_val = 0; sh_neg = 1'b0; sh_err = 1'b0;
  endtask

  function automatic logic [DW-1:0] model_disp();
    logic [DW-1:0] d;
    int v, i;
    d = '1;
    case (md)
      MD_A: begin
        v = a_val;
        for (int j = 0; j < a_n; j++) begin d[4*j +: 4] = 4'(v % 10); v = v / 10; end
      end
      MD_B: begin
        v = b_val;
        for (int j = 0; j < b_n; j++) begin d[4*j +: 4] = 4'(v % 10); v = v / 10; end
        d[DW-4 +: 4] = 4'(op_k);
      end
      default: begin
        if (sh_err) begin
          d = {DISP_DIG{4'hE}};
        end else begin
          v = sh_val; i = 0;
          do begin d[4*i +: 4] = 4'(v % 10); v = v / 10; i++; end while (v > 0);
          if (sh_neg) d[DW-4 +: 4] = 4'hB;
        end
      end
    endcase
    return d;
  endfunction

  // Model reaction to one key outside of the enter-in-B case
  task automatic model_step(input int k);
    if (k == 14) begin
      model_reset();
    end else begin
      case (md)
        MD_A: begin
          if (k <= 9) begin
            if (a_n < OP_DIG) begin a_val = a_val * 10 + k; a_n++; end
          end else if (model_is_op(k)) begin
            op_k = k; md = MD_B;
          end
        end
        MD_B: begin
          if (k <= 9) begin
            if (b_n < OP_DIG) begin b_val = b_val * 10 + k; b_n++; end
          end else if (model_is_op(k)) begin
            op_k = k;
          end
        end
        default: begin
          if (k <= 9) begin
            a_val = k; a_n = 1; b_val = 0; b_n = 0; md = MD_A;
          end
        end
      endcase
    end
  endtask

  task automatic drive_key(input int k);
    @(negedge clk);
    key_valid = 1'b1;
    key       = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Enter in B: time the conversion, optionally clear it after abort_at busy cycles
  task automatic run_enter(input int abort_at, input string tag);
    int r, busy_n, rv_seen, k;
    bit neg, err, aborted;
    neg = 1'b0; err = 1'b0; r = 0;
    case (op_k)
      10: r = a_val + b_val;
      11: begin neg = a_val < b_val; r = neg ? b_val - a_val : a_val - b_val; end
      12: r = a_val * b_val;
      default: begin if (b_val == 0) err = 1'b1; else r = a_val / b_val; end
    endcase
    @(negedge clk);
    key_valid = 1'b1;
    key       = 4'd15;
    @(negedge clk);
    busy_n = 0; rv_seen = 0; aborted = 1'b0;
    while (busy && busy_n < 200) begin
      busy_n++;
      if (result_valid) rv_seen++;
      if (abort_at > 0 && busy_n == abort_at) begin
        key_valid = 1'b1;
        key       = 4'd14;
        @(negedge clk);
        key_valid = 1'b0;
        aborted   = 1'b1;
        break;
      end
      k = $urandom_range(0, 14);
      if (k == 14) k = 15;
      key_valid = 1'($urandom % 2);
      key       = 4'(k);
      @(negedge clk);
    end
    key_valid = 1'b0;
    if (aborted) begin
      model_reset();
      check({tag, "_abort_busy"}, 32'(busy), 32'd0);
      check({tag, "_abort_disp"}, 32'(disp_bcd), 32'(model_disp()));
      rv_seen = 0;
      repeat (res_w + 4) begin
        if (result_valid) rv_seen++;
        @(negedge clk);
      end
      check({tag, "_abort_no_rv"}, 32'(rv_seen), 32'd0);
    end else begin
      md = MD_SHOW; sh_val = r; sh_neg = neg; sh_err = err;
      check({tag, "_busy_len"}, 32'(busy_n), 32'(res_w));
      check({tag, "_rv_early"}, 32'(rv_seen), 32'd0);
      check({tag, "_rv_pulse"}, 32'(result_valid), 32'd1);
      check({tag, "_show"}, 32'(disp_bcd), 32'(model_disp()));
      @(negedge clk);
      check({tag, "_rv_once"}, 32'(result_valid), 32'd0);
    end
  endtask

  task automatic press(input int k, input string tag);
    if (k == 15 && md == MD_B) begin
      if (rand_abort && ($urandom % 6 == 0)) run_enter($urandom_range(1, res_w - 1), tag);
      else                                    run_enter(0, tag);
    end else begin
      drive_key(k);
      model_step(k);
      check({tag, "_disp"}, 32'(disp_bcd), 32'(model_disp()));
      check({tag, "_idle"}, 32'({busy, result_valid}), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, k;
    res_w     = calc_res_w();
    rst       = 1'b1;
    key_valid = 1'b0;
    key       = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_disp", 32'(disp_bcd), 32'hFFFFF);
    check("reset_busy_rv", 32'({busy, result_valid}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_disp", 32'(disp_bcd), 32'hFFFFF);

    // 12 + 34
    press(1, "a1"); press(2, "a2"); press(10, "aop"); press(3, "b3"); press(4, "b4");
    press(15, "sum");
    check("sum_lit", 32'(disp_bcd), 32'hFFF46);

    // 7 - 19 from SHOW
    press(7, "s7"); press(11, "sop"); press(1, "s1"); press(9, "s9");
    press(15, "dif");
    check("dif_lit", 32'(disp_bcd), 32'hBFF12);

    // 99 x 99 with an ignored third digit
    press(9, "m9a"); press(9, "m9b"); press(9, "m9c");
    check("ovr_lit", 32'(disp_bcd), 32'hFFF99);
    press(12, "mop"); press(9, "m9d"); press(9, "m9e");
    press(15, "mul");
    check("mul_lit", 32'(disp_bcd), 32'hF9801);

    press(14, "clr0");
`ifdef CALC_DIV_EN
    press(9, "d9a"); press(9, "d9b"); press(13, "dop"); press(4, "d4");
    press(15, "div");
    check("div_lit", 32'(disp_bcd), 32'hFFF24);
    press(7, "z7"); press(13, "zop"); press(0, "z0");
    press(15, "div0");
    check("div0_lit", 32'(disp_bcd), 32'hEEEEE);
`else
    press(7, "n7"); press(13, "nop");
    check("nodiv_lit", 32'(disp_bcd), 32'hFFFF7);
`endif

    // Clear three cycles into a conversion, then 5 + 5
    press(14, "clr1");
    press(1, "c1"); press(10, "cop"); press(2, "c2");
    run_enter(3, "abort3");
    press(5, "f5"); press(10, "fop"); press(5, "f5b");
    press(15, "five");
    check("five_lit", 32'(disp_bcd), 32'hFFF10);

    // Reset during a conversion
    press(14, "clr2"); press(4, "r4"); press(12, "rop"); press(6, "r6");
    @(negedge clk);
    key_valid = 1'b1;
    key       = 4'd15;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_conv_busy_rv", 32'({busy, result_valid}), 32'd0);
    check("rst_conv_disp", 32'(disp_bcd), 32'hFFFFF);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    r = 0;
    repeat (res_w + 4) begin
      if (result_valid) r++;
      @(negedge clk);
    end
    check("rst_conv_no_rv", 32'(r), 32'd0);

    // Random key stream
    rand_abort = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r = $urandom % 100;
      if (r < 55)      k = $urandom_range(0, 9);
      else if (r < 75) k = $urandom_range(10, 13);
      else if (r < 94) k = 15;
      else             k = 14;
      press(k, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
